// File: rtl/sata_phy_ctrl_if.sv
// Transmit/receive datapath bundle between the GTP wrapper, the OOB engine,
// the link layer and the PHY control block.
interface sata_phy_ctrl_if #(
    parameter int DATA_WIDTH = 32
) ();
    localparam int KW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] oob_data_in;
    logic [KW-1:0]         oob_charisk_in;
    logic [DATA_WIDTH-1:0] link_data_in;
    logic [KW-1:0]         link_charisk_in;
    logic [DATA_WIDTH-1:0] gt_rxdata_in;
    logic [KW-1:0]         gt_rxcharisk_in;
    logic [DATA_WIDTH-1:0] phy_data_out;
    logic [KW-1:0]         phy_charisk_out;

    // Side driving transmit sources and receive data (transceiver/link side)
    modport master (
        output oob_data_in, oob_charisk_in, link_data_in, link_charisk_in,
               gt_rxdata_in, gt_rxcharisk_in,
        input  phy_data_out, phy_charisk_out
    );

    // PHY control block side
    modport slave (
        input  oob_data_in, oob_charisk_in, link_data_in, link_charisk_in,
               gt_rxdata_in, gt_rxcharisk_in,
        output phy_data_out, phy_charisk_out
    );
endinterface

// File: rtl/sata_phy_ctrl.sv
// SATA PHY control: qualifies GTP lock/reset-done, sequences the OOB engine,
// muxes OOB or link transmit data onto the GTP and supervises link health
// via received ALIGN primitives with bounded automatic retry.
module sata_phy_ctrl #(
    parameter int DATA_WIDTH         = 32,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int OOB_TIMEOUT        = 2000000,
    parameter int ALIGN_TIMEOUT      = 1024,
    parameter int RETRY_HOLD         = 16,
    parameter int MAX_RETRY          = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 gt_tx_reset_done_in,
    input  logic                 gt_rx_reset_done_in,
    input  logic                 gt_tx_pll_lock_in,
    input  logic                 gt_rx_pll_lock_in,
    input  logic                 oob_links_up_in,
    sata_phy_ctrl_if.slave       bus,
    output logic                 oob_rst_out,
    output logic                 phy_links_up_out,
    output logic                 phy_error_out,
    output logic [3:0]           retry_count_out
);
    localparam int KW     = DATA_WIDTH / 8;
    localparam int TMAX_A = (OOB_TIMEOUT > ALIGN_TIMEOUT) ? OOB_TIMEOUT : ALIGN_TIMEOUT;
    localparam int TMAX   = (TMAX_A > RETRY_HOLD) ? TMAX_A : RETRY_HOLD;
    localparam int TW     = $clog2(TMAX) + 1;
    localparam int SW     = $clog2(LOCK_STABLE_CYCLES) + 1;

    // Compare against "limit - 1" on the registered value so the transition
    // happens on the edge that completes the N-th cycle.
    localparam logic [TW-1:0] OOB_LAST    = TW'(OOB_TIMEOUT - 1);
    localparam logic [TW-1:0] ALIGN_LAST  = TW'(ALIGN_TIMEOUT - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(RETRY_HOLD - 1);
    localparam logic [TW-1:0] TIMER_SAT   = TW'(TMAX);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_SAT  = SW'(LOCK_STABLE_CYCLES);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET_WAIT,
        ST_OOB,
        ST_LINK_UP,
        ST_RETRY,
        ST_FAILED
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         stable_cnt_q, stable_cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [3:0]            retry_cnt_q, retry_cnt_d;
    logic                  oob_rst_q, oob_rst_d;
    logic                  links_up_q, links_up_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [KW-1:0]         tx_charisk_q, tx_charisk_d;

    logic qual;
    logic align_det;

    assign qual = gt_tx_reset_done_in & gt_rx_reset_done_in &
                  gt_tx_pll_lock_in & gt_rx_pll_lock_in;

    // ALIGN recognition: one word at 32 bits, two consecutive half-words at 16.
    generate
        if (DATA_WIDTH == 32) begin : g_align32
            assign align_det = (bus.gt_rxdata_in == 32'h7B4A4ABC) &&
                               (bus.gt_rxcharisk_in == 4'b0001);
        end else begin : g_align16
            logic first_half_q;

            // Remember that the previous half-word was the K28.5 half of ALIGN
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    first_half_q <= 1'b0;
                end else begin
                    first_half_q <= (bus.gt_rxdata_in == 16'h4ABC) &&
                                    (bus.gt_rxcharisk_in == 2'b01);
                end
            end

            assign align_det = first_half_q &&
                               (bus.gt_rxdata_in == 16'h7B4A) &&
                               (bus.gt_rxcharisk_in == 2'b00);
        end
    endgenerate

    // State, counters and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_RESET_WAIT;
            stable_cnt_q <= '0;
            timer_q      <= '0;
            retry_cnt_q  <= '0;
            oob_rst_q    <= 1'b1;
            links_up_q   <= 1'b0;
            error_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_charisk_q <= '0;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            timer_q      <= timer_d;
            retry_cnt_q  <= retry_cnt_d;
            oob_rst_q    <= oob_rst_d;
            links_up_q   <= links_up_d;
            error_q      <= error_d;
            tx_data_q    <= tx_data_d;
            tx_charisk_q <= tx_charisk_d;
        end
    end

    // Next-state decision plus the qualification, timer and retry counters
    always_comb begin
        logic [3:0] retry_base;

        state_d = state_q;
        case (state_q)
            ST_RESET_WAIT: begin
                if (qual && (stable_cnt_q >= STABLE_LAST)) begin
                    state_d = ST_OOB;
                end
            end
            ST_OOB: begin
                if (!qual) begin
                    state_d = ST_RESET_WAIT;
                end else if (timer_q >= OOB_LAST) begin
                    state_d = ST_RETRY;
                end else if (oob_links_up_in) begin
                    state_d = ST_LINK_UP;
                end
            end
            ST_LINK_UP: begin
                if (!qual) begin
                    state_d = ST_RESET_WAIT;
                end else if (!align_det && (timer_q >= ALIGN_LAST)) begin
                    state_d = ST_RETRY;
                end else if (!oob_links_up_in) begin
                    state_d = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (!qual) begin
                    state_d = ST_RESET_WAIT;
                end else if (timer_q >= HOLD_LAST) begin
                    state_d = (retry_cnt_q >= RETRY_MAX) ? ST_FAILED : ST_OOB;
                end
            end
            ST_FAILED: state_d = ST_FAILED;
            default:   state_d = ST_RESET_WAIT;
        endcase

        if (!qual) begin
            stable_cnt_d = '0;
        end else if (stable_cnt_q == STABLE_SAT) begin
            stable_cnt_d = stable_cnt_q;
        end else begin
            stable_cnt_d = stable_cnt_q + 1'b1;
        end

        // One timer serves OOB, LINK_UP and RETRY; it restarts on every state change.
        if ((state_d != state_q) || (state_d == ST_RESET_WAIT) || (state_d == ST_FAILED)) begin
            timer_d = '0;
        end else if ((state_q == ST_LINK_UP) && align_det) begin
            timer_d = '0;
        end else if (timer_q == TIMER_SAT) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // A received ALIGN proves the attempt succeeded; entering RETRY counts a failure.
        retry_base = ((state_q == ST_LINK_UP) && align_det) ? 4'd0 : retry_cnt_q;
        if ((state_d == ST_RETRY) && (state_q != ST_RETRY)) begin
            retry_cnt_d = (retry_base == 4'hF) ? retry_base : retry_base + 4'd1;
        end else begin
            retry_cnt_d = retry_base;
        end
    end

    // Output values for the coming state, including the transmit switch
    always_comb begin
        oob_rst_d    = 1'b1;
        links_up_d   = 1'b0;
        error_d      = 1'b0;
        tx_data_d    = '0;
        tx_charisk_d = '0;
        case (state_d)
            ST_OOB: begin
                oob_rst_d    = 1'b0;
                tx_data_d    = bus.oob_data_in;
                tx_charisk_d = bus.oob_charisk_in;
            end
            ST_LINK_UP: begin
                oob_rst_d    = 1'b0;
                links_up_d   = 1'b1;
                tx_data_d    = bus.link_data_in;
                tx_charisk_d = bus.link_charisk_in;
            end
            ST_FAILED: error_d = 1'b1;
            default: ;
        endcase
    end

    assign oob_rst_out         = oob_rst_q;
    assign phy_links_up_out    = links_up_q;
    assign phy_error_out       = error_q;
    assign retry_count_out     = retry_cnt_q;
    assign bus.phy_data_out    = tx_data_q;
    assign bus.phy_charisk_out = tx_charisk_q;

endmodule
